// File: rtl/ir.sv
// Instruction register: holds the current 16-bit instruction word.
// It also presents the zero-extended address field and the sign-extended
// immediate field of that word.
// Word layout: [15:12] opcode, [11:8] register field, [7:0] address/immediate.
// The reset input keeps the codebase name rst_n, but it is active-high:
// rst_n = 1 clears the register at once, without waiting for a clock edge.
module ir (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        il_in,
    input  logic [15:0] ins_in,
    output logic [15:0] ins_out,
    output logic [15:0] ia_out,
    output logic [15:0] iv_out
);

    logic [15:0] ir_q;

    // Instruction register: async clear on reset, capture ins_in when il_in is high, otherwise hold
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            ir_q <= 16'h0000;
        end else if (il_in) begin
            ir_q <= ins_in;
        end
    end

    // Outputs decode from the stored word only, so nothing on ins_in reaches them combinationally
    assign ins_out = ir_q;
    assign ia_out  = {8'h00, ir_q[7:0]};
    assign iv_out  = {{8{ir_q[7]}}, ir_q[7:0]};

endmodule

// File: tb/tb_ir.sv
// Bench for the instruction register.
// It runs a table of load/hold vectors, hand-written reset and collision
// sequences, and randomized traffic checked against a behavioural model.
`timescale 1ns/1ps
module tb_ir;

    logic        clk;
    logic        rst_n;
    logic        il_in;
    logic [15:0] ins_in;
    logic [15:0] ins_out;
    logic [15:0] ia_out;
    logic [15:0] iv_out;

    int checks;
    int failures;

    ir dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .il_in   (il_in),
        .ins_in  (ins_in),
        .ins_out (ins_out),
        .ia_out  (ia_out),
        .iv_out  (iv_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        load;
        logic [15:0] ins;
        logic [15:0] exp_ins;
        logic [15:0] exp_ia;
        logic [15:0] exp_iv;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string name, input logic [15:0] e_ins,
                             input logic [15:0] e_ia, input logic [15:0] e_iv);
        check({name, ".ins"}, ins_out, e_ins);
        check({name, ".ia"},  ia_out,  e_ia);
        check({name, ".iv"},  iv_out,  e_iv);
    endtask

    // Drive on the falling edge, then sample 1 ns after the next rising edge
    task automatic step(input logic load, input logic [15:0] ins);
        @(negedge clk);
        il_in  = load;
        ins_in = ins;
        @(posedge clk);
        #1;
    endtask

    // Reference: the address field is the low byte. The immediate is that
    // byte read as a signed 8-bit number, written back as 16-bit two's complement.
    function automatic logic [15:0] ref_ia(input logic [15:0] w);
        int v;
        v = int'(w) % 256;
        return 16'(v);
    endfunction

    function automatic logic [15:0] ref_iv(input logic [15:0] w);
        int v;
        v = int'(w) % 256;
        if (v >= 128) v = v - 256;
        return 16'(v);
    endfunction

    logic [15:0] model_ir;

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b1;
        il_in    = 1'b0;
        ins_in   = 16'h0000;

        // Reset state
        #12;
        check_all("reset", 16'h0000, 16'h0000, 16'h0000);

        // Loading is ignored while reset is held
        il_in  = 1'b1;
        ins_in = 16'h5555;
        @(posedge clk);
        #1;
        check_all("reset_ignores_load", 16'h0000, 16'h0000, 16'h0000);
        @(negedge clk);
        il_in  = 1'b0;
        rst_n  = 1'b0;

        // Vector table: load, sign extension, hold, back-to-back loads
        vecs.push_back('{1'b1, 16'h1234, 16'h1234, 16'h0034, 16'h0034});
        vecs.push_back('{1'b1, 16'hA5F0, 16'hA5F0, 16'h00F0, 16'hFFF0});
        vecs.push_back('{1'b1, 16'h007F, 16'h007F, 16'h007F, 16'h007F});
        vecs.push_back('{1'b1, 16'h1234, 16'h1234, 16'h0034, 16'h0034});
        for (int i = 0; i < 5; i++)
            vecs.push_back('{1'b0, 16'hFFFF, 16'h1234, 16'h0034, 16'h0034});
        vecs.push_back('{1'b1, 16'h0001, 16'h0001, 16'h0001, 16'h0001});
        vecs.push_back('{1'b1, 16'h0080, 16'h0080, 16'h0080, 16'hFF80});
        vecs.push_back('{1'b1, 16'hFF7F, 16'hFF7F, 16'h007F, 16'h007F});
        foreach (vecs[i]) begin
            step(vecs[i].load, vecs[i].ins);
            check_all($sformatf("vec%0d", i), vecs[i].exp_ins, vecs[i].exp_ia, vecs[i].exp_iv);
        end

        // Undriven input while holding must not reach the outputs
        @(negedge clk);
        il_in  = 1'b0;
        ins_in = 16'hxxxx;
        @(posedge clk);
        #1;
        check_all("x_hold", 16'hFF7F, 16'h007F, 16'h007F);

        // Async reset between edges after loading BEEF
        step(1'b1, 16'hBEEF);
        check_all("load_beef", 16'hBEEF, 16'h00EF, 16'hFFEF);
        @(negedge clk);
        il_in = 1'b0;
        #2;
        rst_n = 1'b1;
        #1;
        check_all("async_reset", 16'h0000, 16'h0000, 16'h0000);

        // Reset held across an edge with a load pending: reset wins
        il_in  = 1'b1;
        ins_in = 16'hCAFE;
        @(posedge clk);
        #1;
        check_all("collision", 16'h0000, 16'h0000, 16'h0000);
        @(negedge clk);
        rst_n = 1'b0;
        il_in = 1'b0;
        step(1'b1, 16'hCAFE);
        check_all("after_collision", 16'hCAFE, 16'h00FE, 16'hFFFE);

        // Randomized traffic against the model, with occasional resets
        model_ir = 16'hCAFE;
        for (int n = 0; n < 300; n++) begin
            logic        r;
            logic        l;
            logic [15:0] d;
            r = ($urandom_range(0, 15) == 0);
            l = 1'($urandom_range(0, 1));
            d = 16'($urandom);
            @(negedge clk);
            rst_n  = r;
            il_in  = l;
            ins_in = d;
            if (r) model_ir = 16'h0000;
            @(posedge clk);
            if (!r && l) model_ir = d;
            #1;
            check("rand.ins", ins_out, model_ir);
            check("rand.ia",  ia_out,  ref_ia(model_ir));
            check("rand.iv",  iv_out,  ref_iv(model_ir));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety bound so the run always terminates
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, reached %0t", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ir.md
IR -- requirements
Module: ir

Interface
REQ-001 Parameters: none; all data widths are fixed at 16 bits.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-high (1 = reset asserted), despite the codebase port name.
REQ-004 il_in  input  1  instruction-load enable, sampled on rising clk.
REQ-005 ins_in  input  16  instruction word from memory/bus.
REQ-006 ins_out  output  16  full stored instruction word.
REQ-007 ia_out  output  16  address field of stored instruction, zero-extended.
REQ-008 iv_out  output  16  immediate-value field of stored instruction, sign-extended.

Function
REQ-009 Instruction format: [15:12] opcode, [11:8] register field, [7:0] address/immediate field.
REQ-010 One 16-bit internal register (IR) holds the current instruction.
REQ-011 Rising clk with il_in=1 and reset deasserted: IR <= ins_in; one-cycle latency to outputs.
REQ-012 Rising clk with il_in=0: IR holds its value; ins_in changes have no effect.
REQ-013 ins_out = IR, continuously.
REQ-014 ia_out = {8'h00, IR[7:0]}, combinational from IR only, never from ins_in.
REQ-015 iv_out = {8{IR[7]}, IR[7:0]}, combinational from IR only.
REQ-016 All outputs are glitch-free functions of IR; no combinational path from any input to any output.
REQ-017 il_in held high for consecutive cycles loads a new word every cycle.
REQ-018 X/Z on ins_in with il_in=0 does not propagate to outputs.

Reset
REQ-019 rst_n=1 clears IR to 16'h0000 immediately, without waiting for a clock edge; ins_out=ia_out=iv_out=16'h0000.
REQ-020 While rst_n=1, il_in is ignored and IR stays 16'h0000.
REQ-021 Reset asserted mid-operation (including coincident with an il_in load edge) wins; IR=0.
REQ-022 First load after reset release occurs on the first rising edge with rst_n=0 and il_in=1.

Verification
REQ-023 Reset: rst_n=1 asynchronously between edges, after IR=16'hBEEF -> all outputs 16'h0000 before next edge.
REQ-024 Load: il_in=1, ins_in=16'h1234, one edge -> ins_out=16'h1234, ia_out=16'h0034, iv_out=16'h0034.
REQ-025 Sign extension: load 16'hA5F0 -> ia_out=16'h00F0, iv_out=16'hFFF0; load 16'h007F -> iv_out=16'h007F.
REQ-026 Hold: after loading 16'h1234, il_in=0, ins_in=16'hFFFF for 5 edges -> outputs unchanged (ins_out=16'h1234).
REQ-027 Back-to-back: il_in=1 with ins_in 16'h0001, 16'h0080, 16'hFF7F on three edges -> iv_out sequence 16'h0001, 16'hFF80, 16'h007F.
REQ-028 Reset/load collision: rst_n=1 during an edge with il_in=1, ins_in=16'hCAFE -> IR=16'h0000; after release, next load of 16'hCAFE -> ins_out=16'hCAFE.
